// File: rtl/me_scheduler.sv
// Frame-level block scheduler for the motion-estimation core: walks blocks in raster
// order, sequences the core's 25-phase schedule and buffers one result for downstream.
module me_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cfg_blk_cols,
    input  logic [7:0]  cfg_blk_rows,
    output logic        core_rst,
    output logic [4:0]  core_phase,
    output logic [7:0]  blk_x,
    output logic [7:0]  blk_y,
    input  logic [13:0] core_sad,
    input  logic [3:0]  core_mvx,
    input  logic [3:0]  core_mvy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [13:0] res_sad,
    output logic [3:0]  res_mvx,
    output logic [3:0]  res_mvy,
    output logic [7:0]  res_blk_x,
    output logic [7:0]  res_blk_y,
    output logic        busy,
    output logic        frame_done,
    output logic        cfg_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LAUNCH   = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_WAIT_OUT = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;

    localparam logic [4:0] LAST_PHASE = 5'd24;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [4:0]  phase;
    logic [7:0]  cols_q;
    logic [7:0]  rows_q;
    logic [13:0] sh_sad;
    logic [3:0]  sh_mvx;
    logic [3:0]  sh_mvy;

    logic res_accept;
    logic res_free;
    logic last_col;
    logic last_blk;
    logic at_final;
    logic cap_live;
    logic cap_shadow;
    logic capture;
    logic to_shadow;
    logic start_ok;
    logic cfg_reject;
    logic drain_done;

    always_comb begin
        res_accept = res_valid && res_ready;
        res_free   = !res_valid || res_ready;
        last_col   = (blk_x == cols_q - 8'd1);
        last_blk   = last_col && (blk_y == rows_q - 8'd1);
        at_final   = (state == S_RUN) && (phase == LAST_PHASE);
        cap_live   = at_final && res_free;
        to_shadow  = at_final && !res_free;
        cap_shadow = (state == S_WAIT_OUT) && res_ready;
        capture    = cap_live || cap_shadow;
        start_ok   = (state == S_IDLE) && start &&
                     (cfg_blk_cols != 8'd0) && (cfg_blk_rows != 8'd0);
        cfg_reject = (state == S_IDLE) && start &&
                     ((cfg_blk_cols == 8'd0) || (cfg_blk_rows == 8'd0));
        drain_done = (state == S_DRAIN) && res_free;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start_ok) state_nxt = S_LAUNCH;
            S_LAUNCH:   state_nxt = S_RUN;
            S_RUN: begin
                if (phase == LAST_PHASE) begin
                    if (!res_free)     state_nxt = S_WAIT_OUT;
                    else if (last_blk) state_nxt = S_DRAIN;
                    else               state_nxt = S_LAUNCH;
                end
            end
            S_WAIT_OUT: begin
                if (res_ready) state_nxt = last_blk ? S_DRAIN : S_LAUNCH;
            end
            S_DRAIN:    if (res_free) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // WAIT_OUT holds the core in reset, so its outputs are no longer meaningful there.
    assign core_rst   = (state == S_IDLE) || (state == S_LAUNCH) || (state == S_WAIT_OUT);
    assign core_phase = phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            phase      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            cols_q     <= '0;
            rows_q     <= '0;
        end else begin
            state      <= state_nxt;
            phase      <= (state == S_RUN && phase != LAST_PHASE) ? phase + 5'd1 : '0;
            frame_done <= drain_done;
            cfg_err    <= cfg_reject;
            if (start_ok) begin
                busy   <= 1'b1;
                cols_q <= cfg_blk_cols;
                rows_q <= cfg_blk_rows;
            end else if (drain_done) begin
                busy   <= 1'b0;
            end
        end
    end

    // Block coordinates stay on the final block once the frame is exhausted.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_x <= '0;
            blk_y <= '0;
        end else if (start_ok) begin
            blk_x <= '0;
            blk_y <= '0;
        end else if (capture && !last_blk) begin
            if (last_col) begin
                blk_x <= '0;
                blk_y <= blk_y + 8'd1;
            end else begin
                blk_x <= blk_x + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_sad <= '0;
            sh_mvx <= '0;
            sh_mvy <= '0;
        end else if (to_shadow) begin
            sh_sad <= core_sad;
            sh_mvx <= core_mvx;
            sh_mvy <= core_mvy;
        end
    end

    // A capture in the same cycle as an accept reloads the register and keeps it valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_sad   <= '0;
            res_mvx   <= '0;
            res_mvy   <= '0;
            res_blk_x <= '0;
            res_blk_y <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_sad   <= cap_live ? core_sad : sh_sad;
            res_mvx   <= cap_live ? core_mvx : sh_mvx;
            res_mvy   <= cap_live ? core_mvy : sh_mvy;
            res_blk_x <= blk_x;
            res_blk_y <= blk_y;
        end else if (res_accept) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_me_scheduler.sv
// Self-checking bench for me_scheduler with a behavioural ME core model and a
// raster-order result reference derived from the frame configuration.
module tb_me_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_blk_cols;
    logic [7:0]  cfg_blk_rows;
    logic        core_rst;
    logic [4:0]  core_phase;
    logic [7:0]  blk_x;
    logic [7:0]  blk_y;
    logic [13:0] core_sad;
    logic [3:0]  core_mvx;
    logic [3:0]  core_mvy;
    logic        res_valid;
    logic        res_ready;
    logic [13:0] res_sad;
    logic [3:0]  res_mvx;
    logic [3:0]  res_mvy;
    logic [7:0]  res_blk_x;
    logic [7:0]  res_blk_y;
    logic        busy;
    logic        frame_done;
    logic        cfg_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int          m_cnt = 0;
    logic [31:0] junk = '0;
    int unsigned salt = 0;
    bit          fixed_mode = 1'b0;
    logic [21:0] cv;

    always #5 clk = ~clk;

    me_scheduler dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_blk_cols(cfg_blk_cols), .cfg_blk_rows(cfg_blk_rows),
        .core_rst(core_rst), .core_phase(core_phase), .blk_x(blk_x), .blk_y(blk_y),
        .core_sad(core_sad), .core_mvx(core_mvx), .core_mvy(core_mvy),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sad(res_sad), .res_mvx(res_mvx), .res_mvy(res_mvy),
        .res_blk_x(res_blk_x), .res_blk_y(res_blk_y),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    // Result the core would produce for a block: {sad, mvx, mvy}.
    function automatic logic [21:0] core_val(input logic [7:0] x, input logic [7:0] y,
                                             input int unsigned s, input bit fixed);
        logic [31:0] h;
        if (fixed) return {14'h123, 4'd5, 4'd9};
        h = s ^ ({24'd0, x} * 32'd2654435761) ^ ({24'd0, y} * 32'd40503);
        return h[21:0];
    endfunction

    // Core model: pro_cnt counts from 0 after reset release; result final at 24, junk otherwise.
    always @(posedge clk) m_cnt <= core_rst ? 0 : m_cnt + 1;
    always @(negedge clk) junk <= $urandom;
    assign cv       = core_val(blk_x, blk_y, salt, fixed_mode);
    assign core_sad = core_rst ? '0 : (m_cnt == 24 ? cv[21:8] : junk[13:0]);
    assign core_mvx = core_rst ? '0 : (m_cnt == 24 ? cv[7:4]  : junk[19:16]);
    assign core_mvy = core_rst ? '0 : (m_cnt == 24 ? cv[3:0]  : junk[27:24]);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] out_vec();
        return {core_rst, core_phase, blk_x, blk_y, res_valid, res_sad, res_mvx, res_mvy,
                res_blk_x, res_blk_y, busy, frame_done, cfg_err};
    endfunction

    task automatic test_reset;
        logic [63:0] rv;
        rst = 1'b1; start = 1'b1; cfg_blk_cols = 8'd2; cfg_blk_rows = 8'd2; res_ready = 1'b0;
        tick; tick; tick;
        rv = out_vec();
        vectors++;
        if (rv !== {1'b1, 63'd0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected %h", rv, {1'b1, 63'd0});
        end
        rst = 1'b0; start = 1'b0;
        tick;
        vectors++;
        if (busy !== 1'b0 || core_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_start_ignored: busy=%b core_rst=%b expected 0/1", busy, core_rst);
        end
    endtask

    task automatic test_single_block;
        logic [37:0] got;
        fixed_mode = 1'b1; res_ready = 1'b1;
        cfg_blk_cols = 8'd1; cfg_blk_rows = 8'd1; start = 1'b1;
        tick; start = 1'b0;
        for (int i = 1; i < 26; i++) tick;
        vectors++;
        if (res_valid !== 1'b0 || core_phase !== 5'd24 || core_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL single_phase24: valid=%b phase=%0d core_rst=%b expected 0/24/0",
                     res_valid, core_phase, core_rst);
        end
        tick;
        got = {res_sad, res_mvx, res_mvy, res_blk_x, res_blk_y};
        vectors++;
        if (res_valid !== 1'b1 || got !== {14'h123, 4'd5, 4'd9, 8'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL single_result: valid=%b got %h expected %h", res_valid, got,
                     {14'h123, 4'd5, 4'd9, 8'd0, 8'd0});
        end
        vectors++;
        if (frame_done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy_c27: done=%b busy=%b expected 0/1", frame_done, busy);
        end
        tick;
        vectors++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_c28: done=%b busy=%b valid=%b expected 1/0/0",
                     frame_done, busy, res_valid);
        end
        tick;
        vectors++;
        if (frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_pulse: got %b expected 0", frame_done);
        end
        fixed_mode = 1'b0;
    endtask

    task automatic test_raster(input int cols, input int rows, input bit rand_ready,
                               input bit poke_start);
        int ex[$];
        int ey[$];
        int n, cyc, got, limit;
        bit seen_done, tail;
        logic [21:0] e;
        for (int y = 0; y < rows; y++)
            for (int x = 0; x < cols; x++) begin
                ex.push_back(x);
                ey.push_back(y);
            end
        n = cols * rows; got = 0; seen_done = 0; tail = 0;
        limit = 80 * n + 200;
        salt = $urandom; fixed_mode = 1'b0;
        cfg_blk_cols = 8'(cols); cfg_blk_rows = 8'(rows); start = 1'b1; res_ready = 1'b1;
        tick; start = 1'b0; cyc = 1;
        while (!seen_done && cyc < limit) begin
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (res_valid && res_blk_x == 8'(cols - 1) && res_blk_y == 8'(rows - 1)) tail = 1;
            if (!core_rst && !tail) begin
                vectors++;
                if ({27'd0, core_phase} !== m_cnt) begin
                    miscompares++;
                    $display("FAIL raster_phase: cyc %0d got %0d expected %0d", cyc, core_phase, m_cnt);
                end
            end
            if (res_valid && res_ready) begin
                if (got >= n) begin
                    vectors++; miscompares++;
                    $display("FAIL raster_extra: result %0d beyond expected %0d", got, n);
                end else begin
                    e = core_val(8'(ex[got]), 8'(ey[got]), salt, 1'b0);
                    vectors++;
                    if ({res_sad, res_mvx, res_mvy, res_blk_x, res_blk_y} !==
                        {e, 8'(ex[got]), 8'(ey[got])}) begin
                        miscompares++;
                        $display("FAIL raster_result%0d: got %h expected %h", got,
                                 {res_sad, res_mvx, res_mvy, res_blk_x, res_blk_y},
                                 {e, 8'(ex[got]), 8'(ey[got])});
                    end
                    if (!rand_ready) begin
                        vectors++;
                        if (cyc != 27 + 26 * got) begin
                            miscompares++;
                            $display("FAIL raster_spacing%0d: cyc %0d expected %0d", got, cyc, 27 + 26 * got);
                        end
                    end
                end
                got++;
            end
            if (frame_done) begin
                seen_done = 1;
                vectors++;
                if (got != n || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL raster_done: results %0d busy=%b expected %0d/0", got, busy, n);
                end
                if (!rand_ready) begin
                    vectors++;
                    if (cyc != 26 * n + 2) begin
                        miscompares++;
                        $display("FAIL raster_latency: cyc %0d expected %0d", cyc, 26 * n + 2);
                    end
                end
            end
            start = poke_start && !frame_done && (cyc % 23 == 4);
            if (poke_start && !frame_done) begin
                cfg_blk_cols = 8'($urandom);
                cfg_blk_rows = 8'($urandom);
            end
            if (!seen_done) begin
                tick;
                cyc++;
            end
        end
        start = 1'b0;
        if (!seen_done) begin
            vectors++; miscompares++;
            $display("FAIL raster_timeout: no frame_done within %0d cycles", limit);
        end
    endtask

    task automatic test_backpressure;
        logic [37:0] fld, e0, e1;
        salt = $urandom; fixed_mode = 1'b0;
        e0 = {core_val(8'd0, 8'd0, salt, 1'b0), 8'd0, 8'd0};
        e1 = {core_val(8'd1, 8'd0, salt, 1'b0), 8'd1, 8'd0};
        cfg_blk_cols = 8'd2; cfg_blk_rows = 8'd1; res_ready = 1'b0; start = 1'b1;
        tick; start = 1'b0;
        for (int cyc = 1; cyc <= 135; cyc++) begin
            res_ready = (cyc >= 127);
            fld = {res_sad, res_mvx, res_mvy, res_blk_x, res_blk_y};
            if (cyc >= 27 && cyc <= 127) begin
                vectors++;
                if (res_valid !== 1'b1 || fld !== e0) begin
                    miscompares++;
                    $display("FAIL bp_hold: cyc %0d valid=%b got %h expected %h", cyc, res_valid, fld, e0);
                end
            end
            if (cyc == 128) begin
                vectors++;
                if (res_valid !== 1'b1 || fld !== e1) begin
                    miscompares++;
                    $display("FAIL bp_shadow: valid=%b got %h expected %h", res_valid, fld, e1);
                end
            end
            if (cyc >= 53 && cyc <= 126) begin
                vectors++;
                if (core_rst !== 1'b1 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_wait: cyc %0d core_rst=%b busy=%b expected 1/1", cyc, core_rst, busy);
                end
            end
            vectors++;
            if (frame_done !== (cyc == 129)) begin
                miscompares++;
                $display("FAIL bp_done: cyc %0d got %b expected %b", cyc, frame_done, cyc == 129);
            end
            tick;
        end
    endtask

    task automatic test_cfg_err;
        for (int k = 0; k < 2; k++) begin
            cfg_blk_cols = (k == 0) ? 8'd0 : 8'd4;
            cfg_blk_rows = (k == 0) ? 8'd5 : 8'd0;
            start = 1'b1;
            tick; start = 1'b0;
            vectors++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b1) begin
                miscompares++;
                $display("FAIL cfg_err_pulse%0d: err=%b busy=%b core_rst=%b expected 1/0/1",
                         k, cfg_err, busy, core_rst);
            end
            for (int i = 0; i < 30; i++) begin
                tick;
                vectors++;
                if (cfg_err !== 1'b0 || busy !== 1'b0 || core_rst !== 1'b1) begin
                    miscompares++;
                    $display("FAIL cfg_err_idle%0d: err=%b busy=%b core_rst=%b expected 0/0/1",
                             k, cfg_err, busy, core_rst);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [63:0] rv;
        salt = $urandom; fixed_mode = 1'b0; res_ready = 1'b1;
        cfg_blk_cols = 8'd3; cfg_blk_rows = 8'd2; start = 1'b1;
        tick; start = 1'b0;
        for (int cyc = 1; cyc < 40; cyc++) tick;
        vectors++;
        if (blk_x !== 8'd1 || blk_y !== 8'd0 || core_phase !== 5'd12 || core_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_pos: blk (%0d,%0d) phase %0d expected (1,0) 12", blk_x, blk_y, core_phase);
        end
        rst = 1'b1; start = 1'b1;
        tick;
        rv = out_vec();
        vectors++;
        if (rv !== {1'b1, 63'd0}) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %h expected %h", rv, {1'b1, 63'd0});
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick;
            vectors++;
            if (busy !== 1'b0 || frame_done !== 1'b0 || res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_quiet: busy=%b done=%b valid=%b expected 0/0/0",
                         busy, frame_done, res_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b0;
        cfg_blk_cols = '0; cfg_blk_rows = '0;
        test_reset();
        test_single_block();
        test_raster(3, 2, 1'b0, 1'b0);
        test_backpressure();
        test_cfg_err();
        test_mid_reset();
        test_raster(2, 2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            test_raster($urandom_range(1, 4), $urandom_range(1, 3), 1'b1, 1'b0);
        test_raster(2, 2, 1'b0, 1'b1);
        test_raster(3, 1, 1'b1, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
